// File: rtl/key_event_gen.sv
// Debounces a raw HID keycode into a stable level and queues one event per new press in a small FIFO.
// Optional auto-repeat of the held key is compiled in when KEY_REPEAT_EN is defined.
module key_event_gen #(
  parameter int KEY_W         = 16,
  parameter int STABLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 1024,
  parameter int REPEAT_RATE   = 256
`endif
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic [KEY_W-1:0]                keycode_raw,
  output logic [KEY_W-1:0]                keycode,
  output logic                            press_pulse,
  output logic                            ev_valid,
  output logic [KEY_W-1:0]                ev_code,
  input  logic                            ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]     ev_count,
  output logic                            ev_overflow
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {IDLE, HELD} state_t;

  state_t           state, state_next;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             commit, rep_fire, pulse_next;

  assign commit = (keycode_raw == cand) && (cnt == CNT_W'(STABLE_CYCLES - 1)) && (cand != keycode);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cand    <= '0;
      cnt     <= '0;
      keycode <= '0;
    end else begin
      if (keycode_raw != cand) begin
        cand <= keycode_raw;
        cnt  <= '0;
      end else if (cnt != CNT_W'(STABLE_CYCLES - 1)) begin
        cnt <= cnt + 1'b1;
      end
      if (commit) keycode <= cand;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;

  // First repeat waits REPEAT_DELAY cycles after the commit, later ones REPEAT_RATE.
  assign rep_fire = (state == HELD) && !commit &&
                    (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (commit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state == HELD) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    if (commit) begin
      if (cand != '0) begin
        state_next = HELD;
        pulse_next = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end else if (rep_fire) begin
      pulse_next = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      press_pulse <= pulse_next;
    end
  end

  // Event FIFO: the pulse cycle pushes the now-stable keycode one edge after the commit.
  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop, push_ok;

  assign ev_count = wr_ptr - rd_ptr;
  assign ev_valid = (ev_count != '0);
  assign full     = (ev_count == CW'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = press_pulse && (!full || pop);
  assign ev_code  = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (press_pulse && !push_ok) ev_overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= keycode;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Randomized and directed bench for key_event_gen against a run-length / queue reference model.
// Define KEY_REPEAT_EN to exercise auto-repeat (REPEAT_DELAY=20, REPEAT_RATE=8).
module tb_key_event_gen;
  localparam int KW = 16;
  localparam int S  = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] raw = '0;
  logic          ready = 1'b0;
  logic [KW-1:0] keycode, ev_code;
  logic          press_pulse, ev_valid, ev_overflow;
  logic [2:0]    ev_count;

  key_event_gen #(
    .KEY_W(KW), .STABLE_CYCLES(S), .FIFO_DEPTH(D)
`ifdef KEY_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .keycode_raw(raw), .keycode(keycode),
    .press_pulse(press_pulse), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ready(ready), .ev_count(ev_count), .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a key commits once it has been the sampled value for S+1 consecutive edges.
  logic [KW-1:0] m_key, run_val;
  int            run_len, held_t;
  logic          m_pulse, m_ovf;
  logic [KW-1:0] q[$];

  task automatic model_reset();
    m_key = '0; run_val = '0; run_len = 1; held_t = 0;
    m_pulse = 1'b0; m_ovf = 1'b0; q.delete();
  endtask

  task automatic model_step(input logic [KW-1:0] r, input logic rdy);
    logic np;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (m_pulse) begin
      if (q.size() < D) q.push_back(m_key);
      else m_ovf = 1'b1;
    end
    if (r == run_val) run_len++;
    else begin run_val = r; run_len = 1; end
    np = 1'b0;
    if (run_len >= S + 1 && run_val != m_key) begin
      m_key = run_val;
      np = (run_val != '0);
      held_t = 0;
    end else if (m_key != '0) begin
`ifdef KEY_REPEAT_EN
      held_t++;
      if (held_t == RD || (held_t > RD && (held_t - RD) % RR == 0)) np = 1'b1;
`endif
    end
    m_pulse = np;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        check("rst_keycode", 32'(keycode), 32'h0);
        check("rst_count", 32'(ev_count), 32'h0);
        check("rst_valid", 32'(ev_valid), 32'h0);
      end else begin
        check("keycode", 32'(keycode), 32'(m_key));
        check("press_pulse", 32'(press_pulse), 32'(m_pulse));
        check("ev_count", 32'(ev_count), 32'(q.size()));
        check("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        check("ev_code", 32'(ev_code), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        model_step(raw, ready);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; raw = '0; ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic hold(input logic [KW-1:0] code, input int n, output int pulses);
    raw = code;
    pulses = 0;
    repeat (n) begin @(posedge clk); #1; if (press_pulse) pulses++; end
  endtask

  task automatic pop_expect(input string name, input logic [KW-1:0] exp);
    check(name, 32'(ev_code), 32'(exp));
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask

  int p, tot;

  initial begin
    cyc(2);
    check("reset_overflow", 32'(ev_overflow), 32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Press latency and first event
    raw = 16'h0028;
    cyc(4);
    check("t1_before_commit", 32'(keycode), 32'h0);
    cyc(1);
    check("t1_keycode", 32'(keycode), 32'h28);
    check("t1_pulse", 32'(press_pulse), 32'h1);
    check("t1_valid_late", 32'(ev_valid), 32'h0);
    cyc(1);
    check("t1_pulse_end", 32'(press_pulse), 32'h0);
    check("t1_ev_code", 32'(ev_code), 32'h28);
    check("t1_ev_count", 32'(ev_count), 32'h1);

    // Glitched press gives exactly one event
    do_reset();
    hold(16'h0028, 2, p); tot = p;
    hold(16'h0000, 1, p); tot += p;
    hold(16'h0028, 10, p); tot += p;
    check("t2_events", 32'(tot), 32'h1);
    check("t2_count", 32'(ev_count), 32'h1);

    // Overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      hold(16'(4 + i), 6, p);
      hold(16'h0000, 6, p);
    end
    check("t3_count", 32'(ev_count), 32'h4);
    check("t3_overflow", 32'(ev_overflow), 32'h1);
    for (int i = 0; i < 4; i++) pop_expect("t3_order", 16'(4 + i));
    check("t3_empty", 32'(ev_valid), 32'h0);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hold(16'(16'h10 + i), 6, p);
      hold(16'h0000, 6, p);
    end
    check("t4_full", 32'(ev_count), 32'h4);
    raw = 16'h0033;
    cyc(5);
    check("t4_pulse", 32'(press_pulse), 32'h1);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    check("t4_count", 32'(ev_count), 32'h4);
    check("t4_overflow", 32'(ev_overflow), 32'h0);

    // Direct key change, then release
    do_reset();
    hold(16'h001A, 8, p); tot = p;
    hold(16'h001B, 8, p); tot += p;
    hold(16'h0000, 8, p);
    check("t5_release_events", 32'(p), 32'h0);
    check("t5_events", 32'(tot), 32'h2);
    pop_expect("t5_first", 16'h001A);
    pop_expect("t5_second", 16'h001B);

    // Long hold: auto-repeat when enabled
    do_reset();
    ready = 1'b1;
    hold(16'h0028, 60, p);
`ifdef KEY_REPEAT_EN
    check("t6_events", 32'(p), 32'h6);
`else
    check("t6_events", 32'(p), 32'h1);
`endif
    hold(16'h0000, 8, p);
    ready = 1'b0;

    // Asynchronous reset clears everything without a clock
    do_reset();
    hold(16'h0004, 6, p);
    hold(16'h0005, 6, p);
    hold(16'h0006, 6, p);
    check("t7_count_before", 32'(ev_count), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_keycode", 32'(keycode), 32'h0);
    check("t7_count", 32'(ev_count), 32'h0);
    check("t7_valid", 32'(ev_valid), 32'h0);
    check("t7_code", 32'(ev_code), 32'h0);
    check("t7_pulse", 32'(press_pulse), 32'h0);
    check("t7_overflow", 32'(ev_overflow), 32'h0);
    @(posedge clk); #1;
    raw = '0;
    cyc(1);
    rst_n = 1'b1;

    // Randomized key activity and consumer backpressure
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    raw = 16'h0000;
        2:       raw = 16'h0004;
        3:       raw = 16'h001A;
        default: raw = 16'(16'h0028 + $urandom_range(0, 1));
      endcase
      repeat ($urandom_range(1, 9)) begin
        ready = ($urandom_range(0, 3) == 0);
        cyc(1);
      end
    end
    ready = 1'b0;
    raw = '0;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
